// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: frames SHIFT_WIDTH bits after a start strobe and
// presents each completed word through a one-entry valid/ready output register.
module shift_deser #(
    parameter int    SHIFT_WIDTH     = 4,
    parameter string SHIFT_DIRECTION = "LEFT",
    parameter int    CNT_WIDTH       = 3
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   sclr,
    input  logic                   en,
    input  logic                   start,
    input  logic                   shiftin,
    input  logic                   q_ready,
    output logic [SHIFT_WIDTH-1:0] q,
    output logic                   q_valid,
    output logic                   busy,
    output logic                   overrun,
    output logic                   frame_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam bit                  DIR_RIGHT = (SHIFT_DIRECTION == "RIGHT");
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(SHIFT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                 state, state_nxt;
    logic [SHIFT_WIDTH-1:0] sh, sh_nxt, shifted, fresh, q_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   q_valid_nxt, overrun_nxt, frame_err_nxt;
    logic                   done, pop;

    // fresh = the current bit loaded as bit 0 of a new word (start or resync)
    generate
        if (DIR_RIGHT) begin : g_right
            assign shifted = {shiftin, sh[SHIFT_WIDTH-1:1]};
            assign fresh   = {shiftin, {(SHIFT_WIDTH-1){1'b0}}};
        end else begin : g_left
            assign shifted = {sh[SHIFT_WIDTH-2:0], shiftin};
            assign fresh   = {{(SHIFT_WIDTH-1){1'b0}}, shiftin};
        end
    endgenerate

    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        cnt_nxt       = cnt;
        frame_err_nxt = frame_err;
        done          = 1'b0;
        if (en) begin
            if (state == IDLE) begin
                if (start) begin
                    sh_nxt    = fresh;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = SHIFT;
                end
            end else begin
                if (start) begin
                    sh_nxt        = fresh;
                    cnt_nxt       = CNT_ONE;
                    frame_err_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    done      = 1'b1;
                    sh_nxt    = shifted;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    sh_nxt  = shifted;
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        end

        // A pop on the completing edge frees the slot for the new word
        pop         = q_valid & q_ready;
        q_nxt       = q;
        q_valid_nxt = q_valid;
        overrun_nxt = overrun;
        if (done) begin
            if (!q_valid || pop) begin
                q_nxt       = shifted;
                q_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (pop) begin
            q_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else if (sclr) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh        <= sh_nxt;
            cnt       <= cnt_nxt;
            q         <= q_nxt;
            q_valid   <= q_valid_nxt;
            overrun   <= overrun_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: table of serial words through a scoreboard, then
// hand-written sequences for overrun, pop/complete collision, resync, resets, W=2.
module tb_shift_deser;

    logic       clk = 1'b0;
    logic       aclr_n, sclr, en, start, shiftin, q_ready;
    logic [3:0] q_l, q_r;
    logic [1:0] q_2;
    logic       qv_l, busy_l, ov_l, fe_l;
    logic       qv_r, busy_r, ov_r, fe_r;
    logic       qv_2, busy_2, ov_2, fe_2;

    int vectors    = 0;
    int miscompares = 0;
    bit sb_on      = 1'b0;
    logic [3:0] ql[$];
    logic [3:0] qr[$];

    always #5 clk = ~clk;

    shift_deser #(.SHIFT_WIDTH(4), .SHIFT_DIRECTION("LEFT"), .CNT_WIDTH(3)) dut_l (
        .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .en(en), .start(start), .shiftin(shiftin),
        .q_ready(q_ready), .q(q_l), .q_valid(qv_l), .busy(busy_l), .overrun(ov_l), .frame_err(fe_l));

    shift_deser #(.SHIFT_WIDTH(4), .SHIFT_DIRECTION("RIGHT"), .CNT_WIDTH(3)) dut_r (
        .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .en(en), .start(start), .shiftin(shiftin),
        .q_ready(q_ready), .q(q_r), .q_valid(qv_r), .busy(busy_r), .overrun(ov_r), .frame_err(fe_r));

    shift_deser #(.SHIFT_WIDTH(2), .SHIFT_DIRECTION("LEFT"), .CNT_WIDTH(2)) dut_2 (
        .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .en(en), .start(start), .shiftin(shiftin),
        .q_ready(q_ready), .q(q_2), .q_valid(qv_2), .busy(busy_2), .overrun(ov_2), .frame_err(fe_2));

    // {q, q_valid, busy, overrun, frame_err}
    wire [7:0] stat_l = {q_l, qv_l, busy_l, ov_l, fe_l};
    wire [7:0] stat_r = {q_r, qv_r, busy_r, ov_r, fe_r};
    wire [5:0] stat_2 = {q_2, qv_2, busy_2, ov_2, fe_2};

    typedef struct {
        logic [3:0] serial;   // serial[3] is sent first
        logic       gap;      // idle en=0 cycle after every bit
        logic [3:0] exp_l;
        logic [3:0] exp_r;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic s, input logic b);
        en = 1'b1; start = s; shiftin = b;
        @(posedge clk); #1;
        en = 1'b0; start = 1'b0;
    endtask

    task automatic drive_idle();
        en = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [3:0] w, input logic gap);
        for (int i = 0; i < 4; i++) begin
            drive_bit(i == 0, w[3-i]);
            if (gap) drive_idle();
        end
    endtask

    // Scoreboard: with q_ready=1 each accepted word shows q_valid for one cycle
    always @(negedge clk) begin
        if (sb_on) begin
            if (qv_l) begin
                if (ql.size() == 0) chk("sb_l_unexpected", {28'd0, q_l}, 32'hFFFF_FFFF);
                else chk("sb_l", {28'd0, q_l}, {28'd0, ql.pop_front()});
            end
            if (qv_r) begin
                if (qr.size() == 0) chk("sb_r_unexpected", {28'd0, q_r}, 32'hFFFF_FFFF);
                else chk("sb_r", {28'd0, q_r}, {28'd0, qr.pop_front()});
            end
        end
    end

    initial begin
        tbl[0] = '{4'b1011, 1'b0, 4'b1011, 4'b1101};
        tbl[1] = '{4'b1100, 1'b1, 4'b1100, 4'b0011};
        tbl[2] = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[3] = '{4'b1111, 1'b1, 4'b1111, 4'b1111};
        tbl[4] = '{4'b1000, 1'b0, 4'b1000, 4'b0001};
        tbl[5] = '{4'b0010, 1'b0, 4'b0010, 4'b0100};
        tbl[6] = '{4'b0111, 1'b1, 4'b0111, 4'b1110};
        tbl[7] = '{4'b1001, 1'b0, 4'b1001, 4'b1001};

        aclr_n = 1'b0; sclr = 1'b0; en = 1'b0; start = 1'b0; shiftin = 1'b0; q_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_l", {24'd0, stat_l}, 32'd0);
        chk("reset_r", {24'd0, stat_r}, 32'd0);
        @(posedge clk); #1;
        aclr_n = 1'b1;
        drive_idle();

        // Busy covers bits 2..4, q_valid one cycle after the final bit
        drive_bit(1'b1, 1'b1);
        @(negedge clk); chk("busy_bit2", {24'd0, stat_l}, {24'd0, 4'b0000, 4'b0100});
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        @(negedge clk); chk("busy_bit4", {31'd0, busy_l}, 32'd1);
        drive_bit(1'b0, 1'b1);
        @(negedge clk);
        chk("left_1011", {24'd0, stat_l}, {24'd0, 4'b1011, 4'b1000});
        chk("right_1011", {28'd0, q_r}, {28'd0, 4'b1101});
        drive_idle();
        @(negedge clk); chk("qv_one_cycle", {24'd0, stat_l}, {24'd0, 4'b1011, 4'b0000});

        // Table: back-to-back words (start right after the final bit), some with en gaps
        sb_on = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ql.push_back(tbl[k].exp_l);
            qr.push_back(tbl[k].exp_r);
            send_word(tbl[k].serial, tbl[k].gap);
        end
        drive_idle();
        drive_idle();
        sb_on = 1'b0;
        chk("sb_drain_l", ql.size(), 32'd0);
        chk("sb_drain_r", qr.size(), 32'd0);

        // Overrun: second word dropped while q is held
        q_ready = 1'b0;
        send_word(4'hA, 1'b0);
        @(negedge clk); chk("ovr_first", {24'd0, stat_l}, {24'd0, 4'hA, 4'b1000});
        send_word(4'h5, 1'b0);
        @(negedge clk); chk("ovr_drop", {24'd0, stat_l}, {24'd0, 4'hA, 4'b1010});
        q_ready = 1'b1;
        drive_idle();
        @(negedge clk); chk("ovr_pop", {24'd0, stat_l}, {24'd0, 4'hA, 4'b0010});
        drive_idle();
        @(negedge clk); chk("ovr_sticky", {31'd0, ov_l}, 32'd1);
        sclr = 1'b1;
        drive_idle();
        sclr = 1'b0;
        @(negedge clk); chk("sclr_clear", {24'd0, stat_l}, 32'd0);

        // Pop coinciding with completion replaces q without overrun
        q_ready = 1'b0;
        send_word(4'hA, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        q_ready = 1'b1;
        drive_bit(1'b0, 1'b1);
        @(negedge clk); chk("pop_and_complete", {24'd0, stat_l}, {24'd0, 4'h3, 4'b1000});
        drive_idle();

        // Resync: start after two bits, then a full word 4'h9
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        send_word(4'h9, 1'b0);
        @(negedge clk);
        chk("resync_l", {24'd0, stat_l}, {24'd0, 4'h9, 4'b1001});
        chk("resync_r", {24'd0, stat_r}, {24'd0, 4'h9, 4'b1001});
        drive_idle();

        // Async reset between edges mid-word, with a held word and frame_err set
        q_ready = 1'b0;
        send_word(4'hA, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        #2 aclr_n = 1'b0;
        #1;
        chk("async_rst_l", {24'd0, stat_l}, 32'd0);
        chk("async_rst_r", {24'd0, stat_r}, 32'd0);
        #3 aclr_n = 1'b1;
        q_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        @(negedge clk); chk("no_start_ignored", {24'd0, stat_l}, 32'd0);

        // W=2 completes on the second sampled bit
        drive_bit(1'b1, 1'b1);
        @(negedge clk); chk("w2_busy", {26'd0, stat_2}, {26'd0, 2'b00, 4'b0100});
        drive_bit(1'b0, 1'b0);
        @(negedge clk); chk("w2_word", {26'd0, stat_2}, {26'd0, 2'b10, 4'b1000});
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
